// File: rtl/msx_config_parser.sv
// Typed-record parser from the ioctl download byte stream into block, RAM and SRAM table writes.
// Write strobe is one cycle after the last payload byte; never stalls, so back-to-back bytes are fine.
module msx_config_parser #(
  parameter int MAX_RECORDS = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        block_we,
  output logic [5:0]  block_idx,
  output logic [3:0]  block_ref_ram,
  output logic [1:0]  block_ref_sram,
  output logic [1:0]  block_offset_ram,
  output logic [4:0]  block_mapper,
  output logic [3:0]  block_device,
  output logic        block_cart_num,
  output logic        ram_we,
  output logic [3:0]  ram_idx,
  output logic [26:0] ram_addr,
  output logic [15:0] ram_size,
  output logic        ram_ro,
  output logic        sram_we,
  output logic [1:0]  sram_idx,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_size,
  output logic        done,
  output logic        error,
  output logic [7:0]  rec_count
);

  typedef enum logic [2:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {R_BLOCK, R_RAM, R_SRAM} rec_t;

  state_t      state_q, state_d;
  rec_t        rec_q, rec_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  pb_q [0:7];
  logic [7:0]  pb_d [0:7];
  logic        dl_q;
  logic        done_q, done_d, error_q, error_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        blk_we_q, blk_we_d, ram_we_q, ram_we_d, sram_we_q, sram_we_d;
  logic [5:0]  blk_idx_q, blk_idx_d;
  logic [3:0]  blk_rram_q, blk_rram_d;
  logic [1:0]  blk_rsram_q, blk_rsram_d, blk_ofs_q, blk_ofs_d;
  logic [4:0]  blk_map_q, blk_map_d;
  logic [3:0]  blk_dev_q, blk_dev_d;
  logic        blk_cart_q, blk_cart_d;
  logic [3:0]  ram_idx_q, ram_idx_d;
  logic [26:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_size_q, ram_size_d;
  logic        ram_ro_q, ram_ro_d;
  logic [1:0]  sram_idx_q, sram_idx_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_size_q, sram_size_d;

  logic       dl_rise, dl_fall, wr_ok, last_byte;
  logic [3:0] rec_len;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign wr_ok   = ioctl_wr & ioctl_download;

  always_comb begin
    case (rec_q)
      R_BLOCK: rec_len = 4'd4;
      R_RAM:   rec_len = 4'd8;
      default: rec_len = 4'd6;
    endcase
  end
  assign last_byte = (bcnt_q == rec_len - 4'd1);

  always_comb begin
    state_d     = state_q;
    rec_d       = rec_q;
    bcnt_d      = bcnt_q;
    pb_d        = pb_q;
    done_d      = done_q;
    error_d     = error_q;
    cnt_d       = cnt_q;
    blk_we_d    = 1'b0;
    ram_we_d    = 1'b0;
    sram_we_d   = 1'b0;
    blk_idx_d   = blk_idx_q;
    blk_rram_d  = blk_rram_q;
    blk_rsram_d = blk_rsram_q;
    blk_ofs_d   = blk_ofs_q;
    blk_map_d   = blk_map_q;
    blk_dev_d   = blk_dev_q;
    blk_cart_d  = blk_cart_q;
    ram_idx_d   = ram_idx_q;
    ram_addr_d  = ram_addr_q;
    ram_size_d  = ram_size_q;
    ram_ro_d    = ram_ro_q;
    sram_idx_d  = sram_idx_q;
    sram_addr_d = sram_addr_q;
    sram_size_d = sram_size_q;

    if (dl_rise) begin
      done_d  = 1'b0;
      error_d = 1'b0;
      cnt_d   = '0;
      bcnt_d  = '0;
      state_d = S_TYPE;
    end else begin
      case (state_q)
        S_TYPE: begin
          if (dl_fall) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else if (wr_ok) begin
            bcnt_d  = '0;
            state_d = S_PAYLOAD;
            case (ioctl_dout)
              8'h01:   rec_d = R_BLOCK;
              8'h02:   rec_d = R_RAM;
              8'h03:   rec_d = R_SRAM;
              8'hFF: begin
                done_d  = 1'b1;
                state_d = S_DONE;
              end
              default: begin
                error_d = 1'b1;
                state_d = S_ERR;
              end
            endcase
          end
        end
        S_PAYLOAD: begin
          if (dl_fall) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else if (wr_ok) begin
            pb_d[bcnt_q[2:0]] = ioctl_dout;
            bcnt_d = bcnt_q + 4'd1;
            if (last_byte) begin
              state_d = S_TYPE;
              if (cnt_q != 8'(MAX_RECORDS)) cnt_d = cnt_q + 8'd1;
              case (rec_q)
                R_BLOCK: begin
                  // Out-of-range mapper/device rejects the whole record.
                  if (pb_q[2][4:0] > 5'd17 || ioctl_dout[3:0] > 4'd4) begin
                    cnt_d   = cnt_q;
                    error_d = 1'b1;
                    state_d = S_ERR;
                  end else begin
                    blk_we_d    = 1'b1;
                    blk_idx_d   = pb_q[0][7:2];
                    blk_rram_d  = pb_q[1][7:4];
                    blk_rsram_d = pb_q[1][3:2];
                    blk_ofs_d   = pb_q[1][1:0];
                    blk_cart_d  = pb_q[2][7];
                    blk_map_d   = pb_q[2][4:0];
                    blk_dev_d   = ioctl_dout[3:0];
                  end
                end
                R_RAM: begin
                  ram_we_d   = 1'b1;
                  ram_idx_d  = pb_q[0][3:0];
                  ram_addr_d = {pb_q[4][2:0], pb_q[3], pb_q[2], pb_q[1]};
                  ram_size_d = {pb_q[6], pb_q[5]};
                  ram_ro_d   = ioctl_dout[0];
                end
                default: begin
                  sram_we_d   = 1'b1;
                  sram_idx_d  = pb_q[0][1:0];
                  sram_addr_d = {pb_q[3][1:0], pb_q[2], pb_q[1]};
                  sram_size_d = {ioctl_dout, pb_q[4]};
                end
              endcase
            end
          end
        end
        S_DONE, S_ERR: if (dl_fall) state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  // Edge detector tracks the pin even through reset, so a reset mid-session
  // does not look like a fresh download start.
  always_ff @(posedge clk) dl_q <= ioctl_download;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rec_q       <= R_BLOCK;
      bcnt_q      <= '0;
      for (int i = 0; i < 8; i++) pb_q[i] <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
      blk_we_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      sram_we_q   <= 1'b0;
      blk_idx_q   <= '0;
      blk_rram_q  <= '0;
      blk_rsram_q <= '0;
      blk_ofs_q   <= '0;
      blk_map_q   <= '0;
      blk_dev_q   <= '0;
      blk_cart_q  <= 1'b0;
      ram_idx_q   <= '0;
      ram_addr_q  <= '0;
      ram_size_q  <= '0;
      ram_ro_q    <= 1'b0;
      sram_idx_q  <= '0;
      sram_addr_q <= '0;
      sram_size_q <= '0;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec_d;
      bcnt_q      <= bcnt_d;
      pb_q        <= pb_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
      blk_we_q    <= blk_we_d;
      ram_we_q    <= ram_we_d;
      sram_we_q   <= sram_we_d;
      blk_idx_q   <= blk_idx_d;
      blk_rram_q  <= blk_rram_d;
      blk_rsram_q <= blk_rsram_d;
      blk_ofs_q   <= blk_ofs_d;
      blk_map_q   <= blk_map_d;
      blk_dev_q   <= blk_dev_d;
      blk_cart_q  <= blk_cart_d;
      ram_idx_q   <= ram_idx_d;
      ram_addr_q  <= ram_addr_d;
      ram_size_q  <= ram_size_d;
      ram_ro_q    <= ram_ro_d;
      sram_idx_q  <= sram_idx_d;
      sram_addr_q <= sram_addr_d;
      sram_size_q <= sram_size_d;
    end
  end

  assign block_we         = blk_we_q;
  assign block_idx        = blk_idx_q;
  assign block_ref_ram    = blk_rram_q;
  assign block_ref_sram   = blk_rsram_q;
  assign block_offset_ram = blk_ofs_q;
  assign block_mapper     = blk_map_q;
  assign block_device     = blk_dev_q;
  assign block_cart_num   = blk_cart_q;
  assign ram_we           = ram_we_q;
  assign ram_idx          = ram_idx_q;
  assign ram_addr         = ram_addr_q;
  assign ram_size         = ram_size_q;
  assign ram_ro           = ram_ro_q;
  assign sram_we          = sram_we_q;
  assign sram_idx         = sram_idx_q;
  assign sram_addr        = sram_addr_q;
  assign sram_size        = sram_size_q;
  assign done             = done_q;
  assign error            = error_q;
  assign rec_count        = cnt_q;

endmodule

// File: tb/tb_msx_config_parser.sv
// Directed-vector bench for msx_config_parser; expected values are hand-decoded from the byte streams.
module tb_msx_config_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        block_we;
  logic [5:0]  block_idx;
  logic [3:0]  block_ref_ram;
  logic [1:0]  block_ref_sram;
  logic [1:0]  block_offset_ram;
  logic [4:0]  block_mapper;
  logic [3:0]  block_device;
  logic        block_cart_num;
  logic        ram_we;
  logic [3:0]  ram_idx;
  logic [26:0] ram_addr;
  logic [15:0] ram_size;
  logic        ram_ro;
  logic        sram_we;
  logic [1:0]  sram_idx;
  logic [17:0] sram_addr;
  logic [15:0] sram_size;
  logic        done;
  logic        error;
  logic [7:0]  rec_count;

  int n_vec = 0;
  int n_bad = 0;
  int n_blk = 0;
  int n_ram = 0;
  int n_sram = 0;

  always #5 clk = ~clk;

  msx_config_parser #(.MAX_RECORDS(255)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .block_we(block_we), .block_idx(block_idx), .block_ref_ram(block_ref_ram),
    .block_ref_sram(block_ref_sram), .block_offset_ram(block_offset_ram),
    .block_mapper(block_mapper), .block_device(block_device), .block_cart_num(block_cart_num),
    .ram_we(ram_we), .ram_idx(ram_idx), .ram_addr(ram_addr), .ram_size(ram_size), .ram_ro(ram_ro),
    .sram_we(sram_we), .sram_idx(sram_idx), .sram_addr(sram_addr), .sram_size(sram_size),
    .done(done), .error(error), .rec_count(rec_count)
  );

  // Strobe-high cycles, sampled mid-cycle; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (block_we) n_blk++;
    if (ram_we)   n_ram++;
    if (sram_we)  n_sram++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one byte; ioctl_wr stays high so successive calls are back-to-back.
  task automatic send(input logic [7:0] b);
    ioctl_wr   = 1'b1;
    ioctl_dout = b;
    tick();
  endtask

  task automatic quiet();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_session();
    quiet();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_session();
    quiet();
    ioctl_download = 1'b0;
    tick();
    tick();
  endtask

  int b0;

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_dout = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_block_we", block_we, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rec_count", rec_count, 0);
    chk("rst_ram_addr", ram_addr, 0);

    // BLOCK 01 E4 5B 86 03, then END
    start_session();
    b0 = n_blk;
    send(8'h01); send(8'hE4); send(8'h5B); send(8'h86); send(8'h03);
    quiet();
    chk("blk_we_pulse", block_we, 1);
    chk("blk_idx", block_idx, 32'h39);
    chk("blk_ref_ram", block_ref_ram, 5);
    chk("blk_ref_sram", block_ref_sram, 2);
    chk("blk_offset_ram", block_offset_ram, 3);
    chk("blk_cart_num", block_cart_num, 1);
    chk("blk_mapper", block_mapper, 6);
    chk("blk_device", block_device, 3);
    chk("blk_rec_count", rec_count, 1);
    tick();
    chk("blk_we_low", block_we, 0);
    chk("blk_idx_held", block_idx, 32'h39);
    send(8'hFF);
    quiet();
    tick();
    chk("end_done", done, 1);
    chk("end_rec_count", rec_count, 1);
    chk("blk_pulse_count", n_blk - b0, 1);
    end_session();
    chk("done_sticky", done, 1);

    // RAM on 9 consecutive cycles, then SRAM, then a bad type and an ignored END
    start_session();
    chk("new_sess_done_clr", done, 0);
    chk("new_sess_cnt_clr", rec_count, 0);
    b0 = n_ram;
    send(8'h02); send(8'h07); send(8'h00); send(8'h00); send(8'h12);
    send(8'h05); send(8'h00); send(8'h40); send(8'h01);
    quiet();
    chk("ram_we_pulse", ram_we, 1);
    chk("ram_idx", ram_idx, 7);
    chk("ram_addr", ram_addr, 32'h5120000);
    chk("ram_size", ram_size, 32'h4000);
    chk("ram_ro", ram_ro, 1);
    chk("ram_rec_count", rec_count, 1);
    tick();
    chk("ram_we_low", ram_we, 0);
    chk("ram_pulse_count", n_ram - b0, 1);

    b0 = n_sram;
    send(8'h03); send(8'h02); send(8'h00); send(8'h80);
    send(8'h07); send(8'h00); send(8'h20);
    quiet();
    chk("sram_we_pulse", sram_we, 1);
    chk("sram_idx", sram_idx, 2);
    chk("sram_addr", sram_addr, 32'h38000);
    chk("sram_size", sram_size, 32'h2000);
    chk("sram_rec_count", rec_count, 2);
    tick();
    chk("sram_pulse_count", n_sram - b0, 1);
    send(8'h07);
    quiet();
    chk("badtype_error", error, 1);
    send(8'hFF);
    quiet();
    tick();
    chk("err_ignores_end", done, 0);
    chk("err_rec_count", rec_count, 2);
    end_session();

    // BLOCK with mapper 0x12 is rejected
    start_session();
    b0 = n_blk;
    send(8'h01); send(8'h00); send(8'h00); send(8'h12); send(8'h00);
    quiet();
    tick();
    chk("badmap_no_we", n_blk - b0, 0);
    chk("badmap_error", error, 1);
    chk("badmap_rec_count", rec_count, 0);
    chk("badmap_mapper_held", block_mapper, 6);
    end_session();

    // Download drops after 3 RAM payload bytes
    start_session();
    b0 = n_ram;
    send(8'h02); send(8'h03); send(8'h11); send(8'h22);
    end_session();
    chk("early_no_we", n_ram - b0, 0);
    chk("early_error", error, 1);
    chk("early_idx_held", ram_idx, 7);
    start_session();
    chk("restart_err_clr", error, 0);
    send(8'h02); send(8'h05); send(8'h78); send(8'h56); send(8'h34);
    send(8'h12); send(8'hCD); send(8'hAB); send(8'h00);
    quiet();
    chk("restart_ram_we", ram_we, 1);
    chk("restart_ram_idx", ram_idx, 5);
    chk("restart_ram_addr", ram_addr, 32'h2345678);
    chk("restart_ram_size", ram_size, 32'hABCD);
    chk("restart_ram_ro", ram_ro, 0);
    chk("restart_rec_count", rec_count, 1);
    end_session();

    // Reset in the middle of a BLOCK payload
    start_session();
    b0 = n_blk;
    send(8'h01); send(8'hE4); send(8'h5B);
    quiet();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_block_idx", block_idx, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_sram_size", sram_size, 0);
    chk("midrst_rec_count", rec_count, 0);
    send(8'h86); send(8'h03);
    quiet();
    tick();
    chk("midrst_no_we", n_blk - b0, 0);
    chk("midrst_error", error, 0);
    chk("midrst_mapper", block_mapper, 0);
    end_session();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
